// File: rtl/logic_unit_arbiter.sv
// Shares one N-bit bitwise logic unit (NOT/AND/OR/XOR) among NREQ requesters with round-robin grant.
// Latency: accept at edge T, rsp_valid_o high after edge T+1; at most one op per 3 cycles.
// Backpressure: req_ready_o only in IDLE; rsp_ready_i low holds the result in RESP indefinitely.
//
// Ports:
//   clk_i, rst_i          rising-edge clock, synchronous active-high reset
//   req_valid_i/ready_o   per-requester handshake (ready one-hot or zero)
//   req_op_i/a_i/b_i      per-requester op (2b), operand A, operand B (packed, requester i at slot i)
//   rsp_valid_o/ready_i   result handshake; rsp_id_o names the owner of rsp_data_o
module logic_unit_arbiter #(
    parameter int N    = 32,
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [2*NREQ-1:0]    req_op_i,
    input  logic [N*NREQ-1:0]    req_a_i,
    input  logic [N*NREQ-1:0]    req_b_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [ID_W-1:0]      rsp_id_o,
    output logic [N-1:0]         rsp_data_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_NOT = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;

    state_t          state_q, state_d;
    logic [ID_W-1:0] last_grant_q;
    logic [ID_W-1:0] id_q;
    logic [1:0]      op_q;
    logic [N-1:0]    a_q, b_q;
    logic            rsp_valid_q;
    logic [ID_W-1:0] rsp_id_q;
    logic [N-1:0]    rsp_data_q;

    logic [ID_W-1:0] gnt;
    logic            any_vld;
    logic [N-1:0]    not_a;
    logic [N-1:0]    result;

    // Round-robin scan starting just after the last winner, wrapping at NREQ
    // (NREQ need not be a power of two, so wrap by subtraction rather than masking).
    always_comb begin
        int              idx;
        logic [ID_W-1:0] cand;
        idx     = 0;
        cand    = '0;
        gnt     = '0;
        any_vld = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(last_grant_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            cand = ID_W'(idx);
            if (!any_vld && req_valid_i[cand]) begin
                any_vld = 1'b1;
                gnt     = cand;
            end
        end
    end

    // Shared logic unit: NOT is a per-bit inverter array, the rest are plain bitwise ops.
    for (genvar i = 0; i < N; i++) begin : g_not
        assign not_a[i] = ~a_q[i];
    end

    always_comb begin
        result = not_a;
        unique case (op_q)
            OP_NOT:  result = not_a;
            OP_AND:  result = a_q & b_q;
            OP_OR:   result = a_q | b_q;
            default: result = a_q ^ b_q;
        endcase
    end

    // Next state and request-side ready. Ready is only offered in IDLE, and only to the winner,
    // so a grant and its handshake are the same event.
    always_comb begin
        state_d     = state_q;
        req_ready_o = '0;
        unique case (state_q)
            IDLE: begin
                if (any_vld) begin
                    req_ready_o[gnt] = 1'b1;
                    state_d          = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NREQ - 1);
            id_q         <= '0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (any_vld) begin
                        id_q         <= gnt;
                        last_grant_q <= gnt;
                        op_q         <= req_op_i[2*int'(gnt) +: 2];
                        a_q          <= req_a_i[N*int'(gnt) +: N];
                        b_q          <= req_b_i[N*int'(gnt) +: N];
                    end
                end
                EXEC: begin
                    rsp_data_q  <= result;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_data_o  = rsp_data_q;

endmodule
